// File: rtl/sys_req_responder_pkg.sv
// Shared types for the SYS req/resp responder: bus layouts, privilege and exception codes,
// FSM states and the CSR read-modify-write helper.
package sys_req_responder_pkg;

  localparam int unsigned SYS_XLEN       = 64;
  localparam int unsigned SYS_CSR_ADDR_W = 12;
  localparam int unsigned SYS_ECAUSE_W   = 4;

  localparam logic [1:0] PRIV_LVL_U = 2'd0;
  localparam logic [1:0] PRIV_LVL_S = 2'd1;
  localparam logic [1:0] PRIV_LVL_M = 2'd3;

  localparam logic [SYS_ECAUSE_W-1:0] EXC_ILLEGAL_INSTR = 4'd2;

  typedef enum logic [1:0] {CsrOpNone = 2'd0, CsrOpW = 2'd1, CsrOpS = 2'd2, CsrOpC = 2'd3} csr_op_e;

  typedef enum logic [2:0] {StIdle, StFDwb, StFiDwb, StFiIinv, StSfTlb, StDone} sys_state_e;

  typedef enum logic [1:0] {OpNone, OpFence, OpFencei, OpSfence} sys_op_e;

  // asid carries the full rs2 value; only the low ASID bits reach the TLBs.
  typedef struct packed {
    logic [SYS_XLEN-1:0]       asid;
    logic [SYS_XLEN-1:0]       vaddr;
    logic [SYS_XLEN-1:0]       op1;
    logic [SYS_CSR_ADDR_W-1:0] csr_addr;
    csr_op_e                   csr_op;
    logic                      sfence;
    logic                      fencei;
    logic                      fence;
    logic                      csr_we;
    logic                      csr_re;
  } sys_req_t;

  typedef struct packed {
    logic [SYS_XLEN-1:0]     csr_rddata;
    logic [SYS_ECAUSE_W-1:0] ecause;
    logic                    exception;
    logic                    pipeflush;
    logic [1:0]              priv_lvl;
    logic                    status_tsr;
    logic                    status_tvm;
    logic                    sfence_done;
    logic                    fencei_done;
    logic                    fence_done;
  } sys_resp_t;

  localparam int unsigned SYS_REQ_LEN  = $bits(sys_req_t);
  localparam int unsigned SYS_RESP_LEN = $bits(sys_resp_t);

  function automatic logic [SYS_XLEN-1:0] csr_apply(input csr_op_e op,
                                                    input logic [SYS_XLEN-1:0] rdata,
                                                    input logic [SYS_XLEN-1:0] op1);
    logic [SYS_XLEN-1:0] res;
    res = op1;
    case (op)
      CsrOpS:  res = rdata | op1;
      CsrOpC:  res = rdata & ~op1;
      default: res = op1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sys_csr_access_check.sv
// Combinational CSR access checks: privilege / read-only / illegal exceptions, gated write
// strobe, write data, read data and pipeline-flush request.
module sys_csr_access_check
  import sys_req_responder_pkg::*;
#(
  parameter int unsigned XLEN       = SYS_XLEN,
  parameter int unsigned CSR_ADDR_W = SYS_CSR_ADDR_W
) (
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  re,
  input  logic                  we,
  input  csr_op_e               op,
  input  logic [CSR_ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]       op1,
  input  logic [XLEN-1:0]       csr_rdata,
  input  logic [1:0]            priv_lvl,
  input  logic                  csr_illegal,
  input  logic                  csr_side_effect,
  output logic                  exc,
  output logic                  csr_we,
  output logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rddata,
  output logic                  pipeflush
);

  logic unused_addr;
  assign unused_addr = ^addr[7:0];

  always_comb begin
    // Checks only apply when a CSR access is actually requested.
    exc       = (re | we) & (csr_illegal | (we & (addr[11:10] == 2'b11)) |
                             (addr[9:8] > priv_lvl));
    csr_we    = we & ~exc & ~flush & ~rst;
    rddata    = re ? csr_rdata : '0;
    pipeflush = we & csr_side_effect & ~exc;
    wdata     = csr_apply(op, csr_rdata, op1);
  end

endmodule

// File: rtl/sys_req_responder.sv
// SYS req/resp responder: zero-latency CSR path plus FENCE / FENCE.I / SFENCE.VMA sequencer.
// Define SYS_FENCE_WB_EN to make FENCE perform a D$ writeback-all handshake.
module sys_req_responder
  import sys_req_responder_pkg::*;
#(
  parameter int unsigned XLEN       = SYS_XLEN,
  parameter int unsigned ASID_W     = 16,
  parameter int unsigned CSR_ADDR_W = SYS_CSR_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Flush,
  input  logic [SYS_REQ_LEN-1:0]  SYSreqIn,
  output logic [SYS_RESP_LEN-1:0] SYSrespOut,
  input  logic [1:0]              priv_lvl,
  input  logic                    status_tsr,
  input  logic                    status_tvm,
  output logic                    csr_re,
  output logic                    csr_we,
  output logic [CSR_ADDR_W-1:0]   csr_addr,
  output logic [XLEN-1:0]         csr_wdata,
  input  logic [XLEN-1:0]         csr_rdata,
  input  logic                    csr_illegal,
  input  logic                    csr_side_effect,
  output logic                    dc_wb_req,
  input  logic                    dc_wb_ack,
  output logic                    ic_inv_req,
  input  logic                    ic_inv_ack,
  output logic                    tlb_flush_req,
  input  logic                    tlb_flush_ack,
  output logic [ASID_W-1:0]       tlb_asid,
  output logic [XLEN-1:0]         tlb_vaddr
);

  sys_req_t   req;
  sys_resp_t  resp;
  sys_state_e state_q;
  sys_op_e    op_q;
  logic       abort_q;
  logic       op_req;
  logic       cancel;
  logic       csr_exc;
  logic       chk_pf;
  logic [XLEN-1:0] chk_wdata;
  logic [XLEN-1:0] chk_rddata;
  logic       unused_asid;

  assign req         = sys_req_t'(SYSreqIn);
  assign SYSrespOut  = resp;
  assign unused_asid = ^req.asid[SYS_XLEN-1:ASID_W];

  sys_csr_access_check #(
    .XLEN      (XLEN),
    .CSR_ADDR_W(CSR_ADDR_W)
  ) u_csr_check (
    .rst            (rst),
    .flush          (Flush),
    .re             (req.csr_re),
    .we             (req.csr_we),
    .op             (req.csr_op),
    .addr           (req.csr_addr),
    .op1            (req.op1),
    .csr_rdata      (csr_rdata),
    .priv_lvl       (priv_lvl),
    .csr_illegal    (csr_illegal),
    .csr_side_effect(csr_side_effect),
    .exc            (csr_exc),
    .csr_we         (csr_we),
    .wdata          (chk_wdata),
    .rddata         (chk_rddata),
    .pipeflush      (chk_pf)
  );

  assign csr_re    = req.csr_re & ~rst;
  assign csr_addr  = rst ? '0 : req.csr_addr;
  assign csr_wdata = rst ? '0 : chk_wdata;

  // A sequence is abandoned once Flush is seen or the FU drops its request bit.
  always_comb begin
    op_req = 1'b0;
    case (op_q)
      OpFence:  op_req = req.fence;
      OpFencei: op_req = req.fencei;
      OpSfence: op_req = req.sfence;
      default:  op_req = 1'b0;
    endcase
    cancel = abort_q | Flush | ~op_req;
  end

  always_comb begin
    resp = '0;
    if (!rst) begin
      resp.csr_rddata  = chk_rddata;
      resp.exception   = csr_exc;
      resp.ecause      = csr_exc ? EXC_ILLEGAL_INSTR : '0;
      resp.pipeflush   = chk_pf;
      resp.priv_lvl    = priv_lvl;
      resp.status_tsr  = status_tsr;
      resp.status_tvm  = status_tvm;
      resp.fence_done  = (state_q == StDone) & ~Flush & (op_q == OpFence);
      resp.fencei_done = (state_q == StDone) & ~Flush & (op_q == OpFencei);
      resp.sfence_done = (state_q == StDone) & ~Flush & (op_q == OpSfence);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= OpNone;
      abort_q       <= 1'b0;
      dc_wb_req     <= 1'b0;
      ic_inv_req    <= 1'b0;
      tlb_flush_req <= 1'b0;
      tlb_asid      <= '0;
      tlb_vaddr     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (!Flush) begin
            if (req.fencei) begin
              state_q   <= StFiDwb;
              op_q      <= OpFencei;
              dc_wb_req <= 1'b1;
            end else if (req.sfence) begin
              state_q       <= StSfTlb;
              op_q          <= OpSfence;
              tlb_flush_req <= 1'b1;
              tlb_asid      <= req.asid[ASID_W-1:0];
              tlb_vaddr     <= req.vaddr;
            end else if (req.fence) begin
              op_q <= OpFence;
`ifdef SYS_FENCE_WB_EN
              state_q   <= StFDwb;
              dc_wb_req <= 1'b1;
`else
              state_q <= StDone;
`endif
            end
          end
        end
        StFDwb: begin
          abort_q <= cancel;
          if (dc_wb_ack) begin
            dc_wb_req <= 1'b0;
            state_q   <= cancel ? StIdle : StDone;
          end
        end
        StFiDwb: begin
          abort_q <= cancel;
          if (dc_wb_ack) begin
            dc_wb_req <= 1'b0;
            if (cancel) begin
              state_q <= StIdle;
            end else begin
              state_q    <= StFiIinv;
              ic_inv_req <= 1'b1;
            end
          end
        end
        StFiIinv: begin
          abort_q <= cancel;
          if (ic_inv_ack) begin
            ic_inv_req <= 1'b0;
            state_q    <= cancel ? StIdle : StDone;
          end
        end
        StSfTlb: begin
          abort_q <= cancel;
          if (tlb_flush_ack) begin
            tlb_flush_req <= 1'b0;
            state_q       <= cancel ? StIdle : StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_req_responder.sv
// Bench for sys_req_responder: table-driven CSR vectors plus fence handshake sequences,
// with expected results queued at drive time and checked when the DUT responds.
module tb_sys_req_responder;
  import sys_req_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, Flush;
  sys_req_t                req_s;
  logic [SYS_RESP_LEN-1:0] resp_v;
  sys_resp_t               resp;
  logic [1:0]              priv_lvl;
  logic                    status_tsr, status_tvm;
  logic                    csr_re, csr_we;
  logic [11:0]             csr_addr;
  logic [63:0]             csr_wdata, csr_rdata;
  logic                    csr_illegal, csr_side_effect;
  logic                    dc_wb_req, dc_wb_ack, ic_inv_req, ic_inv_ack;
  logic                    tlb_flush_req, tlb_flush_ack;
  logic [15:0]             tlb_asid;
  logic [63:0]             tlb_vaddr;

  assign resp = sys_resp_t'(resp_v);

  sys_req_responder dut (
    .clk            (clk),
    .rst            (rst),
    .Flush          (Flush),
    .SYSreqIn       (req_s),
    .SYSrespOut     (resp_v),
    .priv_lvl       (priv_lvl),
    .status_tsr     (status_tsr),
    .status_tvm     (status_tvm),
    .csr_re         (csr_re),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .csr_side_effect(csr_side_effect),
    .dc_wb_req      (dc_wb_req),
    .dc_wb_ack      (dc_wb_ack),
    .ic_inv_req     (ic_inv_req),
    .ic_inv_ack     (ic_inv_ack),
    .tlb_flush_req  (tlb_flush_req),
    .tlb_flush_ack  (tlb_flush_ack),
    .tlb_asid       (tlb_asid),
    .tlb_vaddr      (tlb_vaddr)
  );

  typedef struct {
    logic [1:0]  priv;
    logic        re;
    logic        we;
    csr_op_e     op;
    logic [11:0] addr;
    logic [63:0] op1;
    logic [63:0] rdata;
    logic        ill;
    logic        side;
    logic        flush;
    logic        exc;
    logic        we_o;
    logic [63:0] wdata;
    logic [63:0] rddata;
    logic        pf;
  } csr_vec_t;

  localparam int NV = 10;
  csr_vec_t vecs[NV];
  csr_vec_t sb_q[$];
  int       done_q[$];
  int       checks = 0;
  int       errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_ops();
    req_s.fence  = 1'b0;
    req_s.fencei = 1'b0;
    req_s.sfence = 1'b0;
  endtask

  // op: 0 FENCE, 1 FENCE.I, 2 SFENCE.VMA. *_d: ack arrives in the d-th cycle the req is high.
  // Cycle 0 is the cycle the request is first presented.
  task automatic run_op(input string name, input int op, input int dc_d, input int ic_d,
                        input int tlb_d, input int abort_cyc, input bit abort_flush,
                        input int exp_done, input int exp_dc, input int exp_ic, input int exp_tlb);
    int dc_cnt = 0, ic_cnt = 0, tlb_cnt = 0;
    int dc_hi = 0, ic_hi = 0, tlb_hi = 0, overlap = 0, pulses = 0;
    logic [2:0] done;
    logic [2:0] want_kind;
    want_kind = 3'b001 << op;
    if (exp_done >= 0) done_q.push_back(exp_done);
    req_s.fence  = (op == 0);
    req_s.fencei = (op == 1);
    req_s.sfence = (op == 2);
    for (int cyc = 0; cyc < 20; cyc++) begin
      dc_cnt        = dc_wb_req ? dc_cnt + 1 : 0;
      ic_cnt        = ic_inv_req ? ic_cnt + 1 : 0;
      tlb_cnt       = tlb_flush_req ? tlb_cnt + 1 : 0;
      dc_wb_ack     = dc_wb_req && (dc_cnt == dc_d);
      ic_inv_ack    = ic_inv_req && (ic_cnt == ic_d);
      tlb_flush_ack = tlb_flush_req && (tlb_cnt == tlb_d);
      Flush         = abort_flush && (cyc == abort_cyc);
      if (cyc == abort_cyc) drop_ops();
      #1;
      if (dc_wb_req) dc_hi++;
      if (ic_inv_req) ic_hi++;
      if (tlb_flush_req) tlb_hi++;
      if (dc_wb_req && ic_inv_req) overlap++;
      done = {resp.sfence_done, resp.fencei_done, resp.fence_done};
      if (done != 3'b000) begin
        pulses++;
        chk({name, " done_kind"}, done, want_kind);
        chk({name, " done_expected"}, done_q.size(), 1);
        if (done_q.size() != 0) chk({name, " done_cycle"}, cyc, done_q.pop_front());
        drop_ops();
      end
      tick();
    end
    Flush         = 1'b0;
    dc_wb_ack     = 1'b0;
    ic_inv_ack    = 1'b0;
    tlb_flush_ack = 1'b0;
    drop_ops();
    done_q.delete();
    chk({name, " pulses"}, pulses, (exp_done >= 0) ? 1 : 0);
    chk({name, " dc_req_cycles"}, dc_hi, exp_dc);
    chk({name, " ic_req_cycles"}, ic_hi, exp_ic);
    chk({name, " tlb_req_cycles"}, tlb_hi, exp_tlb);
    chk({name, " dc_ic_overlap"}, overlap, 0);
    chk({name, " reqs_idle"}, {dc_wb_req, ic_inv_req, tlb_flush_req}, 3'b000);
  endtask

  initial begin
    csr_vec_t v, e;
    vecs[0] = '{PRIV_LVL_M, 1'b1, 1'b1, CsrOpS, 12'h300, 64'h2, 64'h8, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 64'hA, 64'h8, 1'b0};
    vecs[1] = '{PRIV_LVL_U, 1'b1, 1'b1, CsrOpW, 12'h300, 64'h5, 64'h8, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h8, 1'b0};
    vecs[2] = '{PRIV_LVL_M, 1'b0, 1'b1, CsrOpW, 12'hC00, 64'h5, 64'h8, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h0, 1'b0};
    vecs[3] = '{PRIV_LVL_M, 1'b1, 1'b0, CsrOpNone, 12'hC00, 64'h0, 64'h1234, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 64'h0, 64'h1234, 1'b0};
    vecs[4] = '{PRIV_LVL_S, 1'b1, 1'b1, CsrOpC, 12'h100, 64'hF0, 64'hFF, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b1, 64'h0F, 64'hFF, 1'b1};
    vecs[5] = '{PRIV_LVL_S, 1'b1, 1'b0, CsrOpNone, 12'h300, 64'h0, 64'h77, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h77, 1'b0};
    vecs[6] = '{PRIV_LVL_M, 1'b1, 1'b0, CsrOpNone, 12'h7C0, 64'h0, 64'h99, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h99, 1'b0};
    vecs[7] = '{PRIV_LVL_M, 1'b1, 1'b1, CsrOpW, 12'h180, 64'h1, 64'h42, 1'b0, 1'b1, 1'b1,
                1'b0, 1'b0, 64'h0, 64'h42, 1'b1};
    vecs[8] = '{PRIV_LVL_U, 1'b1, 1'b1, CsrOpS, 12'h000, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 64'h3, 64'h2, 1'b0};
    vecs[9] = '{PRIV_LVL_M, 1'b0, 1'b1, CsrOpW, 12'h340, 64'hDEAD, 64'h5, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 64'hDEAD, 64'h0, 1'b0};

    // Reset with live-looking inputs: every output must still read zero.
    rst             = 1'b1;
    Flush           = 1'b0;
    req_s           = '0;
    req_s.csr_re    = 1'b1;
    req_s.csr_we    = 1'b1;
    req_s.csr_addr  = 12'h300;
    req_s.op1       = 64'h5;
    req_s.fencei    = 1'b1;
    priv_lvl        = PRIV_LVL_M;
    status_tsr      = 1'b1;
    status_tvm      = 1'b1;
    csr_rdata       = 64'hFFFF;
    csr_illegal     = 1'b0;
    csr_side_effect = 1'b1;
    dc_wb_ack       = 1'b0;
    ic_inv_ack      = 1'b0;
    tlb_flush_ack   = 1'b0;
    tick();
    tick();
    chk("reset resp", resp_v, '0);
    chk("reset csr_strobes", {csr_re, csr_we}, 2'b00);
    chk("reset csr_addr", csr_addr, 0);
    chk("reset csr_wdata", csr_wdata, 0);
    chk("reset reqs", {dc_wb_req, ic_inv_req, tlb_flush_req}, 3'b000);
    chk("reset tlb_asid", tlb_asid, 0);
    chk("reset tlb_vaddr", tlb_vaddr, 0);
    req_s = '0;
    rst   = 1'b0;
    tick();

    // CSR path: zero latency, checked in the same cycle the vector is driven.
    for (int i = 0; i < NV; i++) begin
      v                     = vecs[i];
      priv_lvl              = v.priv;
      req_s.csr_re          = v.re;
      req_s.csr_we          = v.we;
      req_s.csr_op          = v.op;
      req_s.csr_addr        = v.addr;
      req_s.op1             = v.op1;
      csr_rdata             = v.rdata;
      csr_illegal           = v.ill;
      csr_side_effect       = v.side;
      Flush                 = v.flush;
      status_tsr            = (i % 2 == 1);
      status_tvm            = (i % 3 == 0);
      sb_q.push_back(v);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("csr%0d exception", i), resp.exception, e.exc);
      chk($sformatf("csr%0d ecause", i), resp.ecause, e.exc ? EXC_ILLEGAL_INSTR : 4'd0);
      chk($sformatf("csr%0d csr_we", i), csr_we, e.we_o);
      chk($sformatf("csr%0d rddata", i), resp.csr_rddata, e.rddata);
      chk($sformatf("csr%0d pipeflush", i), resp.pipeflush, e.pf);
      chk($sformatf("csr%0d priv", i), resp.priv_lvl, e.priv);
      chk($sformatf("csr%0d tsr_tvm", i), {resp.status_tsr, resp.status_tvm},
          {(i % 2 == 1), (i % 3 == 0)});
      if (e.we_o) chk($sformatf("csr%0d wdata", i), csr_wdata, e.wdata);
      tick();
    end
    req_s           = '0;
    Flush           = 1'b0;
    csr_illegal     = 1'b0;
    csr_side_effect = 1'b0;
    tick();

    // FENCE.I: dc ack in its 3rd cycle, ic ack 2 cycles later, DONE the cycle after.
    run_op("fencei", 1, 3, 2, 1, -1, 1'b0, 6, 3, 2, 0);
    run_op("fencei_min", 1, 1, 1, 1, -1, 1'b0, 3, 1, 1, 0);

    req_s.asid  = 64'h5;
    req_s.vaddr = 64'h8000_1000;
    run_op("sfence", 2, 1, 1, 1, -1, 1'b0, 2, 0, 0, 1);
    chk("sfence tlb_asid", tlb_asid, 16'h5);
    chk("sfence tlb_vaddr", tlb_vaddr, 64'h8000_1000);
    req_s.asid  = 64'hABCD_0009;
    req_s.vaddr = 64'h4000;
    run_op("sfence_trunc", 2, 2, 1, 2, -1, 1'b0, 3, 0, 0, 2);
    chk("sfence_trunc tlb_asid", tlb_asid, 16'h9);

`ifdef SYS_FENCE_WB_EN
    run_op("fence_ack1", 0, 1, 1, 1, -1, 1'b0, 2, 1, 0, 0);
    run_op("fence_ack3", 0, 3, 1, 1, -1, 1'b0, 4, 3, 0, 0);
`else
    run_op("fence_ack1", 0, 1, 1, 1, -1, 1'b0, 1, 0, 0, 0);
    run_op("fence_ack3", 0, 3, 1, 1, -1, 1'b0, 1, 0, 0, 0);
`endif

    // Abort corner cases: outstanding req held to its ack, then no further reqs, no DONE.
    run_op("fencei_flush", 1, 3, 1, 1, 2, 1'b1, -1, 3, 0, 0);
    run_op("sfence_drop", 2, 1, 1, 3, 2, 1'b0, -1, 0, 0, 3);
    run_op("sfence_flush_done", 2, 1, 1, 1, 2, 1'b1, -1, 0, 0, 1);
    run_op("fencei_after_abort", 1, 2, 1, 1, -1, 1'b0, 4, 2, 1, 0);

    // rst while SF_TLB waits: the coincident ack is ignored and the req drops next cycle.
    req_s.sfence = 1'b1;
    tick();
    chk("rst_seq tlb_req_up", tlb_flush_req, 1'b1);
    tlb_flush_ack = 1'b1;
    rst           = 1'b1;
    tick();
    chk("rst_seq tlb_req_cleared", tlb_flush_req, 1'b0);
    chk("rst_seq resp_zero", resp_v, '0);
    rst           = 1'b0;
    tlb_flush_ack = 1'b0;
    req_s.sfence  = 1'b0;
    tick();
    tick();
    chk("rst_seq idle", {dc_wb_req, ic_inv_req, tlb_flush_req}, 3'b000);
    chk("rst_seq no_done", {resp.sfence_done, resp.fencei_done, resp.fence_done}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
